// File: rtl/byte_pair_assembler_pkg.sv
// Shared definitions for the byte-pair assembler: data widths and FSM encoding.
package byte_pair_assembler_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    WAIT_FIRST  = 2'd0,
    WAIT_SECOND = 2'd1,
    FULL        = 2'd2
  } state_t;

endpackage

// File: rtl/byte_pair_assembler.sv
// Packs a stream of bytes into 16-bit words with ready/valid handshakes on both
// sides; a word in FULL may be drained and a new first byte taken in one cycle.
module byte_pair_assembler
  import byte_pair_assembler_pkg::*;
#(
  parameter int LOW_FIRST = 1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              flush,
  input  logic [BYTE_W-1:0] byteIn,
  input  logic              byteValid,
  output logic              byteReady,
  output logic [WORD_W-1:0] wordOut,
  output logic              wordValid,
  input  logic              wordReady,
  output logic [7:0]        wordCount
);

  state_t            state_reg, state_next;
  logic [WORD_W-1:0] word_reg, word_next;
  logic [7:0]        count_reg, count_next;
  logic              byte_xfer;
  logic              word_xfer;

  // Writes one byte into the selected half, leaving the other half untouched.
  function automatic logic [WORD_W-1:0] place_byte(input logic [WORD_W-1:0] w,
                                                   input logic [BYTE_W-1:0] b,
                                                   input logic              to_low);
    logic [WORD_W-1:0] r;
    r = w;
    if (to_low) r[BYTE_W-1:0] = b;
    else        r[WORD_W-1:BYTE_W] = b;
    return r;
  endfunction

  localparam logic FIRST_LOW = (LOW_FIRST != 0);

  assign byteReady = (state_reg != FULL) || wordReady;
  assign wordValid = (state_reg == FULL);
  assign wordOut   = word_reg;
  assign wordCount = count_reg;

  assign byte_xfer = byteValid && byteReady;
  assign word_xfer = wordValid && wordReady;

  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    count_next = count_reg;
    if (flush) begin
      // Flush wins over any handshake seen in the same cycle.
      state_next = WAIT_FIRST;
    end else begin
      case (state_reg)
        WAIT_FIRST: begin
          if (byte_xfer) begin
            word_next  = place_byte(word_reg, byteIn, FIRST_LOW);
            state_next = WAIT_SECOND;
          end
        end
        WAIT_SECOND: begin
          if (byte_xfer) begin
            word_next  = place_byte(word_reg, byteIn, !FIRST_LOW);
            state_next = FULL;
          end
        end
        FULL: begin
          if (word_xfer) begin
            count_next = count_reg + 8'd1;
            if (byte_xfer) begin
              word_next  = place_byte(word_reg, byteIn, FIRST_LOW);
              state_next = WAIT_SECOND;
            end else begin
              state_next = WAIT_FIRST;
            end
          end
        end
        default: state_next = WAIT_FIRST;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg <= WAIT_FIRST;
      word_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      word_reg  <= word_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_byte_pair_assembler.sv
// Self-checking bench: two instances (low-first and high-first) share stimulus;
// a negedge monitor models the handshake and scores words from a queue.
module tb_byte_pair_assembler;

  logic        clk = 1'b0;
  logic        resetN;
  logic        flush;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        wordReady;
  logic        byteReady_lo, byteReady_hi;
  logic [15:0] wordOut_lo, wordOut_hi;
  logic        wordValid_lo, wordValid_hi;
  logic [7:0]  wordCount_lo, wordCount_hi;

  int checks = 0;
  int errors = 0;

  // Model state, owned by the monitor.
  logic [31:0] exp_q[$];
  logic        m_full = 1'b0;
  logic        m_have = 1'b0;
  logic [7:0]  m_first = 8'h00;
  logic [7:0]  m_count = 8'h00;

  always #5 clk = ~clk;

  byte_pair_assembler #(.LOW_FIRST(1)) u_lo (
    .clk(clk), .resetN(resetN), .flush(flush), .byteIn(byteIn),
    .byteValid(byteValid), .byteReady(byteReady_lo), .wordOut(wordOut_lo),
    .wordValid(wordValid_lo), .wordReady(wordReady), .wordCount(wordCount_lo)
  );

  byte_pair_assembler #(.LOW_FIRST(0)) u_hi (
    .clk(clk), .resetN(resetN), .flush(flush), .byteIn(byteIn),
    .byteValid(byteValid), .byteReady(byteReady_hi), .wordOut(wordOut_hi),
    .wordValid(wordValid_hi), .wordReady(wordReady), .wordCount(wordCount_hi)
  );

  // Monitor: inputs are stable at negedge, so handshakes about to be sampled are known.
  always @(negedge clk) begin
    logic exp_ready, wx, bx;
    logic [31:0] e;
    if (!resetN) begin
      m_full = 1'b0; m_have = 1'b0; m_count = 8'h00;
      exp_q.delete();
    end else begin
      exp_ready = !m_full || wordReady;
      checks++;
      if (byteReady_lo !== exp_ready || byteReady_hi !== exp_ready) begin
        errors++;
        $display("FAIL mon_byteReady: got %b/%b expected %b", byteReady_lo, byteReady_hi, exp_ready);
      end
      checks++;
      if (wordValid_lo !== m_full || wordValid_hi !== m_full) begin
        errors++;
        $display("FAIL mon_wordValid: got %b/%b expected %b", wordValid_lo, wordValid_hi, m_full);
      end
      if (m_full) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mon_queue: word valid but scoreboard empty");
        end else if (wordOut_lo !== exp_q[0][15:0] || wordOut_hi !== exp_q[0][31:16]) begin
          errors++;
          $display("FAIL mon_wordOut: got %h/%h expected %h/%h", wordOut_lo, wordOut_hi,
                   exp_q[0][15:0], exp_q[0][31:16]);
        end
      end
      checks++;
      if (wordCount_lo !== m_count || wordCount_hi !== m_count) begin
        errors++;
        $display("FAIL mon_wordCount: got %0d/%0d expected %0d", wordCount_lo, wordCount_hi, m_count);
      end
      if (flush) begin
        if (m_full && exp_q.size() > 0) void'(exp_q.pop_front());
        m_full = 1'b0; m_have = 1'b0;
      end else begin
        wx = m_full && wordReady;
        bx = byteValid && exp_ready;
        if (wx) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("word delivered lo=%h hi=%h count=%0d", e[15:0], e[31:16], m_count + 8'd1);
          end
          m_full  = 1'b0;
          m_count = m_count + 8'd1;
        end
        if (bx) begin
          if (!m_have) begin
            m_have = 1'b1; m_first = byteIn;
          end else begin
            exp_q.push_back({m_first, byteIn, byteIn, m_first});
            m_have = 1'b0; m_full = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    tick(); tick();
    #2 resetN = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    resetN = 1'b0; flush = 1'b0; byteIn = 8'h00; byteValid = 1'b0; wordReady = 1'b0;
    #2;
    checks++;
    if (wordValid_lo !== 1'b0 || wordOut_lo !== 16'h0000 || wordCount_lo !== 8'd0 || byteReady_lo !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b out=%h cnt=%0d ready=%b expected 0/0000/0/1",
               wordValid_lo, wordOut_lo, wordCount_lo, byteReady_lo);
    end
    tick(); tick();
    #2 resetN = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    wordReady = 1'b1;
    byteValid = 1'b1; byteIn = 8'h34; tick();
    byteIn = 8'h12; tick();
    byteValid = 1'b0;
    checks++;
    if (wordValid_lo !== 1'b1 || wordOut_lo !== 16'h1234) begin
      errors++;
      $display("FAIL basic_word: valid=%b out=%h expected 1/1234", wordValid_lo, wordOut_lo);
    end
    checks++;
    if (wordOut_hi !== 16'h3412) begin
      errors++;
      $display("FAIL byte_order: got %h expected 3412", wordOut_hi);
    end
    tick();
    checks++;
    if (wordValid_lo !== 1'b0 || wordCount_lo !== 8'd1) begin
      errors++;
      $display("FAIL basic_after: valid=%b cnt=%0d expected 0/1", wordValid_lo, wordCount_lo);
    end
  endtask

  task automatic test_backpressure();
    wordReady = 1'b0;
    byteValid = 1'b1; byteIn = 8'h21; tick();
    byteIn = 8'h43; tick();
    byteIn = 8'h55;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (byteReady_lo !== 1'b0 || wordValid_lo !== 1'b1 || wordOut_lo !== 16'h4321) begin
        errors++;
        $display("FAIL bp_hold[%0d]: ready=%b valid=%b out=%h expected 0/1/4321",
                 k, byteReady_lo, wordValid_lo, wordOut_lo);
      end
      tick();
    end
    wordReady = 1'b1;
    #1;
    checks++;
    if (byteReady_lo !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b expected 1", byteReady_lo);
    end
    tick();
    checks++;
    if (wordValid_lo !== 1'b0 || byteReady_lo !== 1'b1) begin
      errors++;
      $display("FAIL bp_after_xfer: valid=%b ready=%b expected 0/1", wordValid_lo, byteReady_lo);
    end
    byteIn = 8'h66; tick();
    byteValid = 1'b0;
    checks++;
    if (wordValid_lo !== 1'b1 || wordOut_lo !== 16'h6655 || wordOut_hi !== 16'h5566) begin
      errors++;
      $display("FAIL bp_second: valid=%b out=%h/%h expected 1/6655/5566", wordValid_lo, wordOut_lo, wordOut_hi);
    end
    tick();
  endtask

  task automatic test_stream();
    int words = 0;
    do_reset();
    wordReady = 1'b1;
    for (int i = 0; i < 512; i++) begin
      byteValid = 1'b1; byteIn = 8'(i);
      if (i >= 2) begin
        checks++;
        if (wordValid_lo !== ((i % 2) == 0)) begin
          errors++;
          $display("FAIL stream_cadence[%0d]: valid=%b", i, wordValid_lo);
        end
      end
      if (wordValid_lo === 1'b1) words++;
      tick();
    end
    byteValid = 1'b0;
    if (wordValid_lo === 1'b1) words++;
    tick();
    checks++;
    if (words != 256 || wordCount_lo !== 8'd0) begin
      errors++;
      $display("FAIL stream_total: words=%0d cnt=%0d expected 256/0", words, wordCount_lo);
    end
  endtask

  task automatic test_flush();
    wordReady = 1'b1;
    byteValid = 1'b1; byteIn = 8'h77; tick();
    flush = 1'b1; byteIn = 8'h99; tick();
    flush = 1'b0;
    checks++;
    if (wordValid_lo !== 1'b0 || wordCount_lo !== 8'd0) begin
      errors++;
      $display("FAIL flush_state: valid=%b cnt=%0d expected 0/0", wordValid_lo, wordCount_lo);
    end
    byteIn = 8'hAA; tick();
    checks++;
    if (wordValid_lo !== 1'b0) begin
      errors++;
      $display("FAIL flush_discard: valid=%b expected 0", wordValid_lo);
    end
    byteIn = 8'hBB; tick();
    byteValid = 1'b0;
    checks++;
    if (wordValid_lo !== 1'b1 || wordOut_lo !== 16'hBBAA || wordOut_hi !== 16'hAABB) begin
      errors++;
      $display("FAIL flush_word: valid=%b out=%h/%h expected 1/bbaa/aabb", wordValid_lo, wordOut_lo, wordOut_hi);
    end
    tick();
  endtask

  task automatic test_reset_full();
    wordReady = 1'b0;
    byteValid = 1'b1; byteIn = 8'h5A; tick();
    byteIn = 8'hA5; tick();
    byteValid = 1'b0;
    checks++;
    if (wordValid_lo !== 1'b1) begin
      errors++;
      $display("FAIL rstfull_pre: valid=%b expected 1", wordValid_lo);
    end
    #2 resetN = 1'b0;
    #1;
    checks++;
    if (wordValid_lo !== 1'b0 || wordOut_lo !== 16'h0000 || wordOut_hi !== 16'h0000 ||
        wordCount_lo !== 8'd0 || byteReady_lo !== 1'b1) begin
      errors++;
      $display("FAIL rstfull_async: valid=%b out=%h/%h cnt=%0d ready=%b expected 0/0/0/0/1",
               wordValid_lo, wordOut_lo, wordOut_hi, wordCount_lo, byteReady_lo);
    end
    @(posedge clk); #3 resetN = 1'b1;
    tick();
    wordReady = 1'b1;
    byteValid = 1'b1; byteIn = 8'h01; tick();
    byteIn = 8'h02; tick();
    byteValid = 1'b0;
    checks++;
    if (wordValid_lo !== 1'b1 || wordOut_lo !== 16'h0201) begin
      errors++;
      $display("FAIL rstfull_resume: valid=%b out=%h expected 1/0201", wordValid_lo, wordOut_lo);
    end
    tick();
    checks++;
    if (wordCount_lo !== 8'd1) begin
      errors++;
      $display("FAIL rstfull_count: got %0d expected 1", wordCount_lo);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stream();
    test_flush();
    test_reset_full();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
